// File: rtl/mips_debug_ctrl.sv
// ---------------------------------------------------------------------------
// mips_debug_ctrl
// Debug sequencer between a byte-stream host link and the MIPS pipeline.
//   'L' : pulse pipeline reset, then load little-endian words into imem
//         until a HALT word (0) is stored or MAX_INSTR words are written.
//   'C' : run the pipeline until it reports HALT, then dump state.
//   'S' : run the pipeline for one cycle, then dump state.
// The dump is PC followed by registers 0..N_REGS-1, 4 bytes each, LSB first.
//
// Ports
//   i_clk, i_reset            clock, asynchronous active-low reset
//   i_rx_data/i_rx_valid      host byte in (one-cycle strobe)
//   o_tx_data/o_tx_valid      host byte out, held until i_tx_ready
//   o_write/o_address/
//   o_instruction             imem write port
//   o_pipe_reset, o_enable    pipeline reset pulse and clock enable
//   i_halt, i_pc              pipeline status
//   o_reg_addr/i_reg_data     debug register-read port (1-cycle latency)
//   o_busy                    high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module mips_debug_ctrl #(
    parameter int                NB_DATA   = 32,
    parameter int                NB_ADDR   = 32,
    parameter int                NB_REG    = 5,
    parameter int                NB_BYTE   = 8,
    parameter int                N_REGS    = 32,
    parameter int                MAX_INSTR = 256,
    parameter logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C,
    parameter logic [NB_BYTE-1:0] CMD_RUN  = 8'h43,
    parameter logic [NB_BYTE-1:0] CMD_STEP = 8'h53
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_write,
    output logic [NB_ADDR-1:0] o_address,
    output logic [NB_DATA-1:0] o_instruction,
    output logic               o_pipe_reset,
    output logic               o_enable,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    output logic [NB_REG-1:0]  o_reg_addr,
    input  logic [NB_DATA-1:0] i_reg_data,
    output logic               o_busy
);

    localparam int NB_WCNT = $clog2(MAX_INSTR + 1);
    localparam int NB_RIDX = $clog2(N_REGS + 1);
    localparam logic [NB_WCNT-1:0] LAST_WORD = NB_WCNT'(MAX_INSTR - 1);
    localparam logic [NB_RIDX-1:0] REG_END   = NB_RIDX'(N_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WRITE, S_RUN, S_STEP,
        S_DUMP_PC, S_DUMP_SEND, S_DUMP_WAIT, S_DUMP_CAP
    } state_t;

    state_t r_state, w_state_next;

    // Registered outputs
    logic [NB_BYTE-1:0] r_tx_data;
    logic               r_tx_valid, r_write, r_pipe_reset, r_enable, r_busy;
    logic [NB_ADDR-1:0] r_address;
    logic [NB_DATA-1:0] r_instruction;
    logic [NB_REG-1:0]  r_reg_addr;

    // Datapath state
    logic [NB_ADDR-1:0] r_addr_cnt;
    logic [NB_WCNT-1:0] r_word_cnt;
    logic [1:0]         r_rx_cnt, r_tx_cnt;
    logic [NB_DATA-1:0] r_word, r_dump_word;
    logic [NB_RIDX-1:0] r_reg_idx;

    // Next values of the control outputs
    logic w_tx_valid_d, w_write_d, w_pipe_reset_d, w_enable_d, w_busy_d;

    logic w_idle_rx, w_cmd_load, w_cmd_run, w_cmd_step;
    logic w_tx_accept, w_tx_last, w_dump_done, w_load_done;
    logic w_rx_take, w_word_full;
    logic [NB_DATA-1:0] w_word;
    logic [1:0]         w_tx_sel;

    assign w_idle_rx   = (r_state == S_IDLE) && i_rx_valid;
    assign w_cmd_load  = w_idle_rx && (i_rx_data == CMD_LOAD);
    assign w_cmd_run   = w_idle_rx && (i_rx_data == CMD_RUN);
    assign w_cmd_step  = w_idle_rx && (i_rx_data == CMD_STEP);
    assign w_tx_accept = r_tx_valid && i_tx_ready;
    assign w_tx_last   = w_tx_accept && (r_tx_cnt == 2'd3);
    assign w_dump_done = (r_reg_idx == REG_END);
    // Evaluated during the write cycle, where r_instruction is the word being stored.
    assign w_load_done = (r_instruction == '0) || (r_word_cnt == LAST_WORD);
    // A byte landing in the write cycle starts the next word, unless the load ends here.
    assign w_rx_take   = i_rx_valid &&
                         ((r_state == S_LOAD) || ((r_state == S_WRITE) && !w_load_done));
    assign w_word_full = (r_state == S_LOAD) && i_rx_valid && (r_rx_cnt == 2'd3);
    assign w_word      = {i_rx_data, r_word[NB_DATA-NB_BYTE-1:0]};
    assign w_tx_sel    = r_tx_cnt + 2'd1;

    // State and control-output registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_tx_valid   <= 1'b0;
            r_write      <= 1'b0;
            r_pipe_reset <= 1'b0;
            r_enable     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_tx_valid   <= w_tx_valid_d;
            r_write      <= w_write_d;
            r_pipe_reset <= w_pipe_reset_d;
            r_enable     <= w_enable_d;
            r_busy       <= w_busy_d;
        end
    end

    // Next-state logic
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_load)                   w_state_next = S_LOAD;
                else if (w_cmd_run || w_cmd_step) w_state_next = i_halt ? S_DUMP_PC :
                                                                 (w_cmd_run ? S_RUN : S_STEP);
            end
            S_LOAD:      if (w_word_full) w_state_next = S_WRITE;
            S_WRITE:     w_state_next = w_load_done ? S_IDLE : S_LOAD;
            S_RUN:       if (i_halt) w_state_next = S_DUMP_PC;
            S_STEP:      w_state_next = S_DUMP_PC;
            S_DUMP_PC:   w_state_next = S_DUMP_SEND;
            S_DUMP_SEND: if (w_tx_last) w_state_next = w_dump_done ? S_IDLE : S_DUMP_WAIT;
            S_DUMP_WAIT: w_state_next = S_DUMP_CAP;
            S_DUMP_CAP:  w_state_next = S_DUMP_SEND;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Control-output logic (values registered on the next edge)
    always_comb begin
        w_pipe_reset_d = w_cmd_load;
        w_write_d      = w_word_full;
        w_enable_d     = ((w_cmd_run || w_cmd_step) && !i_halt) ||
                         ((r_state == S_RUN) && !i_halt);
        w_busy_d       = (w_state_next != S_IDLE);
        case (r_state)
            S_DUMP_PC, S_DUMP_CAP: w_tx_valid_d = 1'b1;
            S_DUMP_SEND:           w_tx_valid_d = !w_tx_last;
            default:               w_tx_valid_d = 1'b0;
        endcase
    end

    // Load assembly, imem write port and dump serializer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_addr_cnt    <= '0;
            r_word_cnt    <= '0;
            r_rx_cnt      <= '0;
            r_word        <= '0;
            r_address     <= '0;
            r_instruction <= '0;
            r_tx_data     <= '0;
            r_tx_cnt      <= '0;
            r_dump_word   <= '0;
            r_reg_idx     <= '0;
            r_reg_addr    <= '0;
        end else begin
            if (w_cmd_load) begin
                r_addr_cnt <= '0;
                r_word_cnt <= '0;
                r_rx_cnt   <= '0;
            end
            if (w_rx_take) begin
                r_word[r_rx_cnt*NB_BYTE +: NB_BYTE] <= i_rx_data;
                r_rx_cnt <= r_rx_cnt + 2'd1;
            end
            if (w_word_full) begin
                r_instruction <= w_word;
                r_address     <= r_addr_cnt;
            end
            if (r_state == S_WRITE) begin
                r_addr_cnt <= r_addr_cnt + NB_ADDR'(4);
                r_word_cnt <= r_word_cnt + NB_WCNT'(1);
            end
            case (r_state)
                S_DUMP_PC: begin
                    r_dump_word <= NB_DATA'(i_pc);
                    r_tx_data   <= i_pc[NB_BYTE-1:0];
                    r_tx_cnt    <= '0;
                    r_reg_idx   <= '0;
                end
                S_DUMP_SEND: begin
                    if (w_tx_accept) begin
                        if (r_tx_cnt == 2'd3) begin
                            r_reg_addr <= r_reg_idx[NB_REG-1:0];
                        end else begin
                            // Next byte is presented the cycle after acceptance.
                            r_tx_cnt  <= w_tx_sel;
                            r_tx_data <= r_dump_word[w_tx_sel*NB_BYTE +: NB_BYTE];
                        end
                    end
                end
                S_DUMP_CAP: begin
                    r_dump_word <= i_reg_data;
                    r_tx_data   <= i_reg_data[NB_BYTE-1:0];
                    r_tx_cnt    <= '0;
                    r_reg_idx   <= r_reg_idx + NB_RIDX'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_tx_data     = r_tx_data;
    assign o_tx_valid    = r_tx_valid;
    assign o_write       = r_write;
    assign o_address     = r_address;
    assign o_instruction = r_instruction;
    assign o_pipe_reset  = r_pipe_reset;
    assign o_enable      = r_enable;
    assign o_reg_addr    = r_reg_addr;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_debug_ctrl
// Self-checking bench: drives host bytes, stubs the pipeline (halt after a
// programmable number of enabled cycles, PC, 1-cycle-latency register file)
// and compares imem writes, enable cycles and dump bytes against expectations
// computed from the command rules.
// ---------------------------------------------------------------------------
module tb_mips_debug_ctrl;

    localparam int NB_DATA   = 32;
    localparam int NB_ADDR   = 32;
    localparam int NB_REG    = 5;
    localparam int NB_BYTE   = 8;
    localparam int N_REGS    = 32;
    localparam int MAX_INSTR = 4;
    localparam int DUMP_LEN  = 4 + 4 * N_REGS;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NB_BYTE-1:0] rx_data;
    logic               rx_valid;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               write;
    logic [NB_ADDR-1:0] address;
    logic [NB_DATA-1:0] instruction;
    logic               pipe_reset;
    logic               enable;
    logic               halt;
    logic [NB_ADDR-1:0] pc;
    logic [NB_REG-1:0]  reg_addr;
    logic [NB_DATA-1:0] reg_q;
    logic               busy;

    always #5 clk = ~clk;

    mips_debug_ctrl #(
        .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG),
        .NB_BYTE(NB_BYTE), .N_REGS(N_REGS), .MAX_INSTR(MAX_INSTR)
    ) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_write(write), .o_address(address), .o_instruction(instruction),
        .o_pipe_reset(pipe_reset), .o_enable(enable),
        .i_halt(halt), .i_pc(pc),
        .o_reg_addr(reg_addr), .i_reg_data(reg_q),
        .o_busy(busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- pipeline stub ----------------
    logic [31:0] regs [N_REGS];
    int          halt_after = 0;
    bit          halt_force = 1'b0;
    int          en_base    = 0;
    int          n_en       = 0;

    always @(posedge clk) reg_q <= regs[reg_addr];
    // HALT retires during the halt_after-th enabled cycle.
    assign halt = halt_force || ((halt_after != 0) && ((n_en - en_base) >= halt_after));

    // ---------------- monitors ----------------
    logic [63:0] wq [$];
    logic [7:0]  txq [$];
    int          n_preset   = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = '0;

    always @(negedge clk) begin
        if (write)             wq.push_back({address, instruction});
        if (pipe_reset)        n_preset++;
        if (enable)            n_en++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (write || enable || pipe_reset)
            check("strobe_exclusive", 32'($countones({write, enable, pipe_reset})), 32'd1);
        if (prev_stall) begin
            check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            check("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    // ---------------- tx_ready pattern ----------------
    int rdy_mode = 0;  // 0: always ready, 1: ready 1-in-3 cycles, 2: random
    int rdy_phase = 0;
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       begin rdy_phase = (rdy_phase + 1) % 3; tx_ready = (rdy_phase == 0); end
                2:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [7:0]  v;
        for (int b = 0; b < 4; b++) begin
            do v = 8'($urandom_range(0, 255));
            while (v == 8'h4C || v == 8'h43 || v == 8'h53);
            w[8*b +: 8] = v;
        end
        return w;
    endfunction

    // Load: expected writes are the words up to and including the first zero,
    // capped at MAX_INSTR, at consecutive word addresses.
    task automatic do_load(input logic [31:0] words [$], input int max_gap);
        logic [63:0] exp [$];
        int          pr0;
        for (int i = 0; i < words.size(); i++) begin
            exp.push_back({32'(4 * i), words[i]});
            if (words[i] == 32'h0 || exp.size() == MAX_INSTR) break;
        end
        wq.delete();
        pr0 = n_preset;
        send_byte(8'h4C, $urandom_range(0, max_gap));
        for (int i = 0; i < words.size(); i++)
            for (int b = 0; b < 4; b++)
                send_byte(words[i][8*b +: 8], $urandom_range(0, max_gap));
        wait_idle(200);
        check("load_nwrites", wq.size(), exp.size());
        for (int i = 0; i < wq.size() && i < exp.size(); i++) begin
            check("load_addr", wq[i][63:32], exp[i][63:32]);
            check("load_data", wq[i][31:0], exp[i][31:0]);
        end
        check("load_pipe_reset", n_preset - pr0, 1);
    endtask

    // Run/step: expected dump is PC then every register, LSB first.
    task automatic do_dump(input logic [7:0] cmd, input int h_after, input bit h_force,
                           input int mode, input int exp_en, input bit junk);
        logic [7:0] exp [$];
        int         pr0, nw0;
        for (int b = 0; b < 4; b++) exp.push_back(pc[8*b +: 8]);
        for (int r = 0; r < N_REGS; r++)
            for (int b = 0; b < 4; b++) exp.push_back(regs[r][8*b +: 8]);
        rdy_mode   = mode;
        halt_after = h_after;
        halt_force = h_force;
        en_base    = n_en;
        txq.delete();
        pr0 = n_preset;
        nw0 = wq.size();
        send_byte(cmd, 0);
        if (junk) send_byte(8'h4C, 0);
        wait_idle(5000);
        check("enable_cycles", n_en - en_base, exp_en);
        check("dump_len", txq.size(), DUMP_LEN);
        for (int i = 0; i < txq.size() && i < exp.size(); i++)
            check("dump_byte", {24'd0, txq[i]}, {24'd0, exp[i]});
        check("dump_no_preset", n_preset - pr0, 0);
        check("dump_no_write", wq.size() - nw0, 0);
        halt_after = 0;
        halt_force = 1'b0;
        rdy_mode   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_write"}, {31'd0, write}, 32'd0);
        check({tag, "_address"}, address, 32'd0);
        check({tag, "_instr"}, instruction, 32'd0);
        check({tag, "_pipe_reset"}, {31'd0, pipe_reset}, 32'd0);
        check({tag, "_enable"}, {31'd0, enable}, 32'd0);
        check({tag, "_reg_addr"}, {27'd0, reg_addr}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] words [$];
        rst_n    = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;
        pc       = '0;
        for (int r = 0; r < N_REGS; r++) regs[r] = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;

        // Reset in the middle of a load discards the partial word.
        send_byte(8'h4C, 0);
        send_byte(8'h20, 0);
        send_byte(8'h18, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        // Load one instruction followed by HALT.
        words = '{32'h0022_1820, 32'h0000_0000};
        do_load(words, 0);

        // Load limit: the fifth word falls into IDLE and is ignored.
        words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 32'h1122_3344};
        do_load(words, 1);

        // Randomized loads, random spacing including back-to-back bytes.
        for (int t = 0; t < 3; t++) begin
            words.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++)
                words.push_back(($urandom_range(0, 4) == 0) ? 32'h0 : rand_word());
            words.push_back(32'h0);
            do_load(words, (t == 0) ? 0 : 2);
        end

        // Continuous run: halt after 5 enabled cycles, PC 0x14, r3 = 4.
        pc = 32'h14;
        regs[3] = 32'd4;
        do_dump(8'h43, 5, 1'b0, 0, 5, 1'b0);

        // Single step under 1-in-3 backpressure, junk byte while busy.
        pc = $urandom();
        for (int r = 0; r < N_REGS; r++) regs[r] = $urandom();
        do_dump(8'h53, 0, 1'b0, 1, 1, 1'b1);

        // Already halted: no enable, dump still produced.
        do_dump(8'h43, 0, 1'b1, 2, 0, 1'b1);
        do_dump(8'h53, 0, 1'b1, 0, 0, 1'b0);

        // Randomized runs.
        for (int t = 0; t < 2; t++) begin
            int ha;
            ha = $urandom_range(1, 8);
            pc = $urandom();
            for (int r = 0; r < N_REGS; r++) regs[r] = $urandom();
            do_dump(8'h43, ha, 1'b0, 2, ha, 1'b1);
        end

        // An unknown command byte leaves the sequencer idle.
        send_byte(8'h11, 0);
        check("unknown_cmd_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
